// File: rtl/echo_mem_pkg.sv
// rtl/echo_mem_pkg.sv - shared widths and state type for the echo memory DMA master
package echo_mem_pkg;
  localparam int ADDR_W    = 13;
  localparam int DATA_W    = 32;
  localparam int LEN_W     = 14;
  localparam int MEM_DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_WRITE,
    ST_FINISH
  } dma_state_t;
endpackage

// File: rtl/echo_skid_fifo2.sv
// rtl/echo_skid_fifo2.sv - two-entry valid/ready FIFO for the read return path
module echo_skid_fifo2 #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_tvalid,
  input  logic [W-1:0] push_tdata,
  input  logic         pop_tready,
  output logic         pop_tvalid,
  output logic [W-1:0] pop_tdata,
  output logic [1:0]   count
);
  logic [W-1:0] slot [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         pop;

  // The producer only pushes when space is guaranteed, so there is no push-side ready.
  assign pop_tvalid = (count != 2'd0);
  assign pop_tdata  = slot[rd_ptr];
  assign pop        = pop_tvalid & pop_tready;

  always_ff @(posedge clk) begin
    if (reset) begin
      slot[0] <= '0;
      slot[1] <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
    end else begin
      if (push_tvalid) begin
        slot[wr_ptr] <= push_tdata;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push_tvalid} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/echo_mem_dma_master.sv
// rtl/echo_mem_dma_master.sv - Avalon-MM master moving word blocks between on-chip memory and LVDS streams
module echo_mem_dma_master
  import echo_mem_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [LEN_W-1:0]    cmd_len,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   avm_address,
  output logic [DATA_W/8-1:0] avm_byteenable,
  output logic                avm_chipselect,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  input  logic [DATA_W-1:0]   avm_readdata,
  output logic                avm_clken,
  output logic                src_valid,
  input  logic                src_ready,
  output logic [DATA_W-1:0]   src_data,
  output logic                src_last,
  input  logic                snk_valid,
  output logic                snk_ready,
  input  logic [DATA_W-1:0]   snk_data
);
  dma_state_t        state;
  dma_state_t        state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  remaining;
  logic [LEN_W-1:0]  accept_left;
  logic              rd_inflight;
  logic              rd_inflight_last;
  logic              wr_pending;
  logic [DATA_W-1:0] wr_data;
  logic              cmd_fire;
  logic              rd_issue;
  logic              pop;
  logic              snk_fire;
  logic              last_access;
  logic [1:0]        fifo_count;
  logic [2:0]        fifo_occ;
  logic [DATA_W:0]   fifo_head;

  assign cmd_fire    = cmd_valid & cmd_ready;
  assign pop         = src_valid & src_ready;
  assign last_access = (remaining == LEN_W'(1));

  // Occupancy the FIFO will have once this cycle's pop and the in-flight return settle.
  assign fifo_occ = {1'b0, fifo_count} + {2'b00, rd_inflight} - {2'b00, pop};
  assign rd_issue = (state == ST_READ) && (remaining != '0) && (fifo_occ < 3'd2);

  assign snk_ready = (state == ST_WRITE) && (accept_left != '0);
  assign snk_fire  = snk_valid & snk_ready;

  assign avm_chipselect = rd_issue | wr_pending;
  assign avm_write      = wr_pending;
  assign avm_address    = addr;
  assign avm_writedata  = wr_data;
  assign avm_byteenable = '1;
  assign avm_clken      = 1'b1;

  assign src_data = fifo_head[DATA_W-1:0];
  assign src_last = src_valid & fifo_head[DATA_W];

  echo_skid_fifo2 #(
    .W(DATA_W + 1)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_tvalid(rd_inflight),
    .push_tdata ({rd_inflight_last, avm_readdata}),
    .pop_tready (src_ready),
    .pop_tvalid (src_valid),
    .pop_tdata  (fifo_head),
    .count      (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_IDLE;
      addr             <= '0;
      remaining        <= '0;
      accept_left      <= '0;
      rd_inflight      <= 1'b0;
      rd_inflight_last <= 1'b0;
      wr_pending       <= 1'b0;
      wr_data          <= '0;
    end else begin
      state <= state_nxt;
      if (cmd_fire) begin
        addr        <= cmd_addr;
        remaining   <= cmd_len;
        accept_left <= cmd_write ? cmd_len : '0;
      end else if (avm_chipselect) begin
        addr      <= addr + ADDR_W'(1);
        remaining <= remaining - LEN_W'(1);
      end
      if (snk_fire) begin
        accept_left <= accept_left - LEN_W'(1);
        wr_data     <= snk_data;
      end
      wr_pending       <= snk_fire;
      rd_inflight      <= rd_issue;
      rd_inflight_last <= rd_issue & last_access;
    end
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_fire) begin
          if (cmd_len == '0)  state_nxt = ST_FINISH;
          else if (cmd_write) state_nxt = ST_WRITE;
          else                state_nxt = ST_READ;
        end
      end
      ST_READ: begin
        if (rd_issue && last_access) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Leave as the final word is popped so done lands one cycle later.
        if (!rd_inflight && ((fifo_count == 2'd0) || (fifo_count == 2'd1 && pop)))
          state_nxt = ST_FINISH;
      end
      ST_WRITE: begin
        if (wr_pending && last_access) state_nxt = ST_FINISH;
      end
      ST_FINISH: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end
endmodule
